// File: rtl/fifo_mem_pkg.sv
// Shared types and helpers for the multi-channel FIFO.
package fifo_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int PAR_MAX_W = 256;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers zero-extend their word; padding zeros do not change the XOR.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_ch_ptr.sv
// One channel's read/write pointers, registered full/empty flags and error flags.
module fifo_ch_ptr #(
  parameter int AW           = 4,
  parameter int STICKY_ERROR = 1
) (
  input  logic          wclk,
  input  logic          hw_rst_n,
  input  logic          sw_rst,
  input  logic          ptr_clr,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          full,
  output logic          empty,
  output logic          wr_overflow,
  output logic          rd_underflow
);

  logic [AW:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic        ovf, unf;

  assign wr_acc   = wr_req & ~full;
  assign rd_acc   = rd_req & ~empty;
  assign ovf      = wr_req & full;
  assign unf      = rd_req & empty;
  assign waddr    = wptr[AW-1:0];
  assign raddr    = rptr[AW-1:0];
  assign wptr_nxt = ptr_clr ? '0 : wptr + (AW+1)'(wr_acc);
  assign rptr_nxt = ptr_clr ? '0 : rptr + (AW+1)'(rd_acc);

  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else if (sw_rst) begin
      wptr         <= '0;
      rptr         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      empty <= (wptr_nxt == rptr_nxt);
      full  <= (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
      if (STICKY_ERROR != 0) begin
        wr_overflow  <= wr_overflow | ovf;
        rd_underflow <= rd_underflow | unf;
      end else begin
        wr_overflow  <= ovf;
        rd_underflow <= unf;
      end
    end
  end

endmodule

// File: rtl/fifo_mem_mchan.sv
// Single-clock multi-channel FIFO over one shared array, with a sequential clear engine.
// Define FIFO_MEM_PARITY_EN to add a stored even-parity bit and the par_err output.
//
// state | meaning
// IDLE  | normal FIFO traffic, waiting for mem_clr
// CLEAR | zeroing one array word per cycle, traffic blocked
module fifo_mem_mchan
  import fifo_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CH_NUM       = 4,
  parameter int CH_DEPTH     = 16,
  parameter int PIPE_READ    = 0,
  parameter int STICKY_ERROR = 1
) (
  input  logic                       wclk,
  input  logic                       hw_rst_n,
  input  logic                       sw_rst,
  input  logic                       mem_clr,
  input  logic                       wr_en,
  input  logic [idx_width(CH_NUM)-1:0] wr_ch,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       rd_en,
  input  logic [idx_width(CH_NUM)-1:0] rd_ch,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rvalid,
  output logic [CH_NUM-1:0]          full,
  output logic [CH_NUM-1:0]          empty,
  output logic [CH_NUM-1:0]          wr_overflow,
  output logic [CH_NUM-1:0]          rd_underflow,
  output logic                       clr_busy
`ifdef FIFO_MEM_PARITY_EN
  , output logic                     par_err
`endif
);

  localparam int CW  = idx_width(CH_NUM);
  localparam int AW  = idx_width(CH_DEPTH);
  localparam int MAW = CW + AW;
`ifdef FIFO_MEM_PARITY_EN
  localparam int MW  = DATA_WIDTH + 1;
`else
  localparam int MW  = DATA_WIDTH;
`endif

  logic [MW-1:0]     mem [CH_NUM*CH_DEPTH];
  clr_state_e        state;
  logic [MAW-1:0]    clr_addr;
  logic              ptr_clr;
  logic [CH_NUM-1:0] wr_req, rd_req, wr_acc, rd_acc, full_q;
  logic [AW-1:0]     waddr_ch [CH_NUM];
  logic [AW-1:0]     raddr_ch [CH_NUM];
  logic              wr_any, rd_any;
  logic [MAW-1:0]    waddr, raddr;
  logic [MW-1:0]     wword, rword, out_word;
  logic              out_v;

  assign ptr_clr = (state == IDLE) & mem_clr & ~sw_rst;
  assign wr_any  = |wr_acc;
  assign rd_any  = |rd_acc;
  assign waddr   = {wr_ch, waddr_ch[wr_ch]};
  assign raddr   = {rd_ch, raddr_ch[rd_ch]};
  assign full    = clr_busy ? '1 : full_q;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign wr_req[i] = wr_en & (wr_ch == CW'(i)) & ~clr_busy;
    assign rd_req[i] = rd_en & (rd_ch == CW'(i)) & ~clr_busy;
    fifo_ch_ptr #(.AW(AW), .STICKY_ERROR(STICKY_ERROR)) u_ptr (
      .wclk(wclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .ptr_clr(ptr_clr),
      .wr_req(wr_req[i]), .rd_req(rd_req[i]), .wr_acc(wr_acc[i]), .rd_acc(rd_acc[i]),
      .waddr(waddr_ch[i]), .raddr(raddr_ch[i]), .full(full_q[i]), .empty(empty[i]),
      .wr_overflow(wr_overflow[i]), .rd_underflow(rd_underflow[i])
    );
  end

  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_addr <= '0;
    end else if (sw_rst) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: if (mem_clr) begin
          state    <= CLEAR;
          clr_busy <= 1'b1;
          clr_addr <= '0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_MEM_PARITY_EN
  assign wword = {even_parity(PAR_MAX_W'(wdata)), wdata};
`else
  assign wword = wdata;
`endif

  // The array has no reset; its contents are only defined after writes or a clear.
  always_ff @(posedge wclk) begin
    if (clr_busy) mem[clr_addr] <= '0;
    else if (wr_any) mem[waddr] <= wword;
  end

  assign rword = mem[raddr];

  if (PIPE_READ != 0) begin : g_pipe
    logic [MW-1:0] pipe_word;
    logic          pipe_v;
    always_ff @(posedge wclk or negedge hw_rst_n) begin
      if (!hw_rst_n) begin
        pipe_word <= '0;
        pipe_v    <= 1'b0;
      end else if (sw_rst) begin
        pipe_word <= '0;
        pipe_v    <= 1'b0;
      end else begin
        pipe_v <= rd_any;
        if (rd_any) pipe_word <= rword;
      end
    end
    assign out_word = pipe_word;
    assign out_v    = pipe_v;
  end else begin : g_nopipe
    assign out_word = rword;
    assign out_v    = rd_any;
  end

  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (sw_rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= out_v;
      if (out_v) rdata <= out_word[DATA_WIDTH-1:0];
    end
  end

`ifdef FIFO_MEM_PARITY_EN
  logic par_bad;
  assign par_bad = out_v & (^out_word);
  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) par_err <= 1'b0;
    else if (sw_rst) par_err <= 1'b0;
    else if (STICKY_ERROR != 0) par_err <= par_err | par_bad;
    else par_err <= par_bad;
  end
`endif

endmodule

// File: tb/tb_fifo_mem_mchan.sv
// Bench for fifo_mem_mchan: two instances (1-cycle/sticky and 2-cycle/pulse) share stimulus.
module tb_fifo_mem_mchan;

  localparam int DEPTH = 16;
  localparam int TOTAL = 64;

  logic        wclk = 1'b0, hw_rst_n = 1'b0, sw_rst = 1'b0, mem_clr = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]  wr_ch = '0, rd_ch = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, clr_busy0, clr_busy1;
  logic [3:0]  full0, empty0, ovf0, unf0, full1, empty1, ovf1, unf1;
`ifdef FIFO_MEM_PARITY_EN
  logic        par_err0, par_err1;
`endif

  fifo_mem_mchan #(.PIPE_READ(0), .STICKY_ERROR(1)) u_dut0 (
    .wclk(wclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .mem_clr(mem_clr),
    .wr_en(wr_en), .wr_ch(wr_ch), .wdata(wdata), .rd_en(rd_en), .rd_ch(rd_ch),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .wr_overflow(ovf0), .rd_underflow(unf0), .clr_busy(clr_busy0)
`ifdef FIFO_MEM_PARITY_EN
    , .par_err(par_err0)
`endif
  );

  fifo_mem_mchan #(.PIPE_READ(1), .STICKY_ERROR(0)) u_dut1 (
    .wclk(wclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .mem_clr(mem_clr),
    .wr_en(wr_en), .wr_ch(wr_ch), .wdata(wdata), .rd_en(rd_en), .rd_ch(rd_ch),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .wr_overflow(ovf1), .rd_underflow(unf1), .clr_busy(clr_busy1)
`ifdef FIFO_MEM_PARITY_EN
    , .par_err(par_err1)
`endif
  );

  typedef struct {
    logic [31:0] d;
    int          due;
  } sb_t;

  sb_t         sb0[$], sb1[$];
  sb_t         e0, e1;
  logic [31:0] mq[4][$];
  int          cyc = 0, n_tests = 0, n_fail = 0, clr_left = 0;
  logic [3:0]  ovf_s = '0, unf_s = '0, ovf_p = '0, unf_p = '0;
  logic [31:0] last0 = '0, last1 = '0;
  bit          mon_en = 1'b0;

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Read-side scoreboard: data and arrival cycle per instance.
  always @(negedge wclk) begin
    if (mon_en) begin
      if (rvalid0) begin
        if (sb0.size() == 0) check_eq("p0_extra_rvalid", sb0.size(), 1);
        else begin
          e0 = sb0.pop_front();
          check_eq("p0_rdata", rdata0, e0.d);
          check_eq("p0_latency", cyc, e0.due);
          last0 = e0.d;
        end
      end else check_eq("p0_rdata_hold", rdata0, last0);
      if (rvalid1) begin
        if (sb1.size() == 0) check_eq("p1_extra_rvalid", sb1.size(), 1);
        else begin
          e1 = sb1.pop_front();
          check_eq("p1_rdata", rdata1, e1.d);
          check_eq("p1_latency", cyc, e1.due);
          last1 = e1.d;
        end
      end else check_eq("p1_rdata_hold", rdata1, last1);
`ifdef FIFO_MEM_PARITY_EN
      check_eq("p0_par_err", par_err0, 0);
      check_eq("p1_par_err", par_err1, 0);
`endif
    end
  end

  task automatic tick(input bit w = 0, input int wc = 0, input logic [31:0] wd = '0,
                      input bit r = 0, input int rc = 0, input bit clr = 0, input bit srst = 0);
    int          clr_next;
    bit          busy, wok, rok;
    logic [31:0] d;
    logic [3:0]  ef, ee;
    wr_en = w; wr_ch = wc[1:0]; wdata = wd;
    rd_en = r; rd_ch = rc[1:0]; mem_clr = clr; sw_rst = srst;
    busy = (clr_left > 0);
    clr_next = clr_left;
    ovf_p = '0;
    unf_p = '0;
    if (!srst) begin
      if (!busy) begin
        wok = mq[wc].size() < DEPTH;
        rok = mq[rc].size() > 0;
        if (w && !wok) ovf_p[wc] = 1'b1;
        if (r && !rok) unf_p[rc] = 1'b1;
        if (r && rok) begin
          d = mq[rc].pop_front();
          sb0.push_back('{d, cyc + 1});
          sb1.push_back('{d, cyc + 2});
        end
        if (w && wok) mq[wc].push_back(wd);
        if (clr) begin
          clr_next = TOTAL;
          for (int c = 0; c < 4; c++) mq[c].delete();
        end
      end else clr_next = clr_left - 1;
    end
    @(posedge wclk); #1;
    if (srst) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
      ovf_s = '0; unf_s = '0; clr_next = 0; last0 = '0; last1 = '0;
    end else begin
      ovf_s = ovf_s | ovf_p;
      unf_s = unf_s | unf_p;
    end
    clr_left = clr_next;
    for (int c = 0; c < 4; c++) begin
      ef[c] = (mq[c].size() == DEPTH);
      ee[c] = (mq[c].size() == 0);
    end
    if (clr_left > 0) ef = 4'hF;
    check_eq("p0_full", full0, ef);
    check_eq("p1_full", full1, ef);
    check_eq("p0_empty", empty0, ee);
    check_eq("p1_empty", empty1, ee);
    check_eq("p0_clr_busy", clr_busy0, clr_left > 0);
    check_eq("p1_clr_busy", clr_busy1, clr_left > 0);
    check_eq("p0_overflow_sticky", ovf0, ovf_s);
    check_eq("p0_underflow_sticky", unf0, unf_s);
    check_eq("p1_overflow_pulse", ovf1, ovf_p);
    check_eq("p1_underflow_pulse", unf1, unf_p);
  endtask

  initial begin
    repeat (3) @(posedge wclk);
    #1 hw_rst_n = 1'b1;
    mon_en = 1'b1;
    check_eq("rst_rvalid0", rvalid0, 0);
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_empty0", empty0, 4'hF);
    check_eq("rst_full0", full0, 0);
    check_eq("rst_busy0", clr_busy0, 0);
    check_eq("rst_rvalid1", rvalid1, 0);
    tick();

    // In-order data on ch2, other channels untouched
    for (int i = 0; i < 16; i++) tick(1, 2, 32'hA0 + i);
    for (int i = 0; i < 16; i++) tick(.r(1), .rc(2));
    repeat (3) tick();

    // Fill ch1 then one more write that must be dropped
    for (int i = 0; i < 17; i++) tick(1, 1, 32'h100 + i);
    for (int i = 0; i < 16; i++) tick(.r(1), .rc(1));
    repeat (2) tick();

    tick(.r(1), .rc(3));
    tick();

    // Interleaved back-to-back reads across channels
    tick(1, 0, 32'hC0); tick(1, 0, 32'hC1); tick(1, 1, 32'hD0);
    tick(.r(1), .rc(0)); tick(.r(1), .rc(1)); tick(.r(1), .rc(0));
    repeat (3) tick();

    // Pointer wrap at constant occupancy 8
    for (int i = 0; i < 8; i++) tick(1, 0, 32'h200 + i);
    for (int i = 8; i < 48; i++) tick(1, 0, 32'h200 + i, 1, 0);
    for (int i = 0; i < 8; i++) tick(.r(1), .rc(0));
    repeat (3) tick();

    // Same-channel write+read at empty and at full
    tick(1, 3, 32'h300, 1, 3);
    for (int i = 1; i < 16; i++) tick(1, 3, 32'h300 + i);
    tick(1, 3, 32'h3FF, 1, 3);
    for (int i = 0; i < 15; i++) tick(.r(1), .rc(3));
    repeat (3) tick();

    // Full clear with traffic attempted while busy
    for (int i = 0; i < 5; i++) tick(1, 0, 32'h400 + i);
    repeat (3) tick();
    tick(.clr(1));
    for (int i = 0; i < 70; i++)
      tick((i % 3) == 0, 0, 32'hBAD0 + i, (i % 4) == 1, 0, i == 10);
    tick(1, 0, 32'h500); tick(1, 0, 32'h501);
    for (int i = 0; i < 30; i++) tick(.r(1), .rc(0));
    repeat (3) tick();

    // Soft reset aborts a clear, and beats mem_clr in the same cycle
    tick(1, 2, 32'h600);
    tick(.clr(1));
    repeat (10) tick();
    tick(.srst(1));
    tick();
    tick(.r(1), .rc(2));
    repeat (3) tick();
    tick(.clr(1), .srst(1));
    tick();

    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 1), $urandom_range(0, 3), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 3));
    repeat (4) tick();
    check_eq("p0_sb_drained", sb0.size(), 0);
    check_eq("p1_sb_drained", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_mem_mchan.md
# fifo_mem_mchan

Single-clock, multi-channel FIFO buffer: CH_NUM independent logical FIFOs share one DATA_WIDTH × (CH_NUM·CH_DEPTH) storage array. Each channel has its own pointers, full/empty flags and error reporting. A sequential memory-clear state machine replaces reset-time array clearing. It sits between a channelised producer and consumer in the wclk domain, where the async FIFO's dual-clock split is unnecessary.

## Interface
- DATA_WIDTH, 32, word width
- CH_NUM, 4, channel count, power of 2, ≥2
- CH_DEPTH, 16, words per channel, power of 2, ≥4
- PIPE_READ, 0, 0 = 1-cycle read latency; 1 = 2-cycle, registered array output
- STICKY_ERROR, 1, 1 = error flags hold until reset; 0 = one-cycle pulses

- wclk  in  1  clock, all logic rising-edge
- hw_rst_n  in  1  reset hw_rst_n, asynchronous, active-low; clock wclk
- sw_rst  in  1  synchronous soft reset: pointers, flags, read pipeline, FSM
- mem_clr  in  1  pulse, starts array clear
- wr_en  in  1  write request
- wr_ch  in  log2(CH_NUM)  write channel
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_ch  in  log2(CH_NUM)  read channel
- rdata  out  DATA_WIDTH  read data, valid with rvalid
- rvalid  out  1  read data valid
- full  out  CH_NUM  per-channel full
- empty  out  CH_NUM  per-channel empty
- wr_overflow  out  CH_NUM  write to full channel
- rd_underflow  out  CH_NUM  read from empty channel
- clr_busy  out  1  clear in progress
- par_err  out  1  parity error, present only with FIFO_MEM_PARITY_EN

## Operation
- Physical address is {ch, ptr[AW-1:0]}, with AW = log2(CH_DEPTH). Per-channel wptr/rptr are AW+1 bits.
- Flags: empty when wptr==rptr; full when MSBs differ and the low AW bits are equal. Flags are registered and reflect state after the previous edge.
- Write accepted: wr_en & !full[wr_ch] & !clr_busy. Array written at the edge; wptr increments, wrapping naturally.
- Write attempted on a full channel: no array write, no pointer change, wr_overflow[wr_ch] set.
- Read accepted: rd_en & !empty[rd_ch] & !clr_busy. rptr increments; data is returned per Timing.
- Read attempted on an empty channel: no pointer change, no rvalid, rd_underflow[rd_ch] set.
- Same-channel write and read in one cycle: each is judged on the pre-edge flags.
  - Write to full + read: overflow, read proceeds.
  - Read from empty + write: underflow, write proceeds.
  - No write-through or bypass.
- Clear FSM states:
  - IDLE → CLEAR on mem_clr.
  - CLEAR writes zero to one address per cycle, 0 to CH_NUM·CH_DEPTH−1, then → IDLE.
  - On CLEAR entry, all pointers reset.
  - During CLEAR: clr_busy=1, full forced all-1, wr_en/rd_en ignored without setting error flags, mem_clr ignored.
- sw_rst, highest priority after hw_rst_n:
  - Resets pointers, flags, errors, rvalid and read pipeline; FSM goes to IDLE, aborting any clear.
  - Array contents are kept.
  - Beats mem_clr in the same cycle.
- Reset values, hw_rst_n or sw_rst: rdata=0, rvalid=0, full=0, empty=all-1, wr_overflow=0, rd_underflow=0, clr_busy=0, par_err=0. Array contents are undefined after hw_rst_n.

## Timing
- PIPE_READ=0: rdata/rvalid at edge N+1 for a read accepted at edge N.
- PIPE_READ=1: rdata/rvalid at edge N+2. One read is accepted per cycle in both modes, fully pipelined.
- rvalid is high for exactly one cycle per accepted read. rdata holds its last value while rvalid=0.
- Flags update one edge after the accepted operation.
- Error flags assert one edge after the offending request.
- Clear takes exactly CH_NUM·CH_DEPTH cycles. clr_busy is high from the edge after mem_clr through the last clear write. Reads already in the pipeline at clear entry still complete.

## Configuration
- FIFO_MEM_PARITY_EN defined:
  - Array is DATA_WIDTH+1 wide, storing even parity of wdata.
  - Parity is checked on the read path alongside rvalid.
  - par_err follows the STICKY_ERROR rule.
  - Clear writes parity 0.
- Undefined: no parity bit, no par_err port, array is DATA_WIDTH wide.

## Structure
- Package fifo_mem_pkg holds:
  - clr_state_e (IDLE, CLEAR)
  - a clog2-based width helper
  - the parity function
- Sub-module fifo_ch_ptr: one channel's wptr/rptr, full/empty and overflow/underflow logic. Instantiated CH_NUM times via generate; accept strobes come from the top.

## Test plan
- CH_NUM=4, CH_DEPTH=16, PIPE_READ=0: write 0xA0..0xAF to ch2, read 16 → rdata matches in order, one cycle after each rd_en; empty[2]=1 after the last read; other channels untouched.
- Fill ch1 with 16 words, then a 17th write → full[1]=1, wr_overflow[1]=1 (sticky), 17th word never read back.
- Read ch3 when empty → rd_underflow[3]=1, rvalid stays 0. With STICKY_ERROR=0 the flag is a 1-cycle pulse.
- Interleaved channels, PIPE_READ=1: back-to-back reads ch0/ch1/ch0 → rvalid on 3 consecutive cycles starting 2 cycles after the first rd_en; data per channel order.
- Wrap-around: 40 write/read pairs on ch0 at occupancy 8 → never full, data intact across pointer wrap.
- Clear: mem_clr with ch0 holding 5 words → clr_busy for 64 cycles, full=4'hF meanwhile. Afterwards empty=4'hF; writing then reading ch0 returns the new data. sw_rst mid-clear → clr_busy drops next edge.
